// File: rtl/conv_win3x3_gen_8ch.sv
// 3x3 sliding-window generator for an 8-channel int4 raster stream, two line buffers, no padding, stride 1.
// Optional WIN_LAST_EN macro adds a win_last output flagging the final window of each frame.
module conv_win3x3_gen_8ch #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [31:0] pix_data,
  output logic        win_valid,
  output logic [35:0] ifm_win3x3_0,
  output logic [35:0] ifm_win3x3_1,
  output logic [35:0] ifm_win3x3_2,
  output logic [35:0] ifm_win3x3_3,
  output logic [35:0] ifm_win3x3_4,
  output logic [35:0] ifm_win3x3_5,
  output logic [35:0] ifm_win3x3_6,
  output logic [35:0] ifm_win3x3_7,
`ifdef WIN_LAST_EN
  output logic        win_last,
`endif
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          last_col, last_row, emit, last_pix;

  logic [31:0] line1_mem [IMG_W];
  logic [31:0] line2_mem [IMG_W];
  logic [31:0] l1_rd, l2_rd;

  logic [31:0] win_q [3][3];
  logic [31:0] win_d [3][3];
  logic [35:0] out_q [8];
  logic [35:0] out_d [8];

  logic win_valid_q, frame_done_q;

  // A start-of-frame pixel is forced to (0,0) whatever the counters hold.
  always_comb begin
    col_eff  = pix_sof ? '0 : col_q;
    row_eff  = pix_sof ? '0 : row_q;
    last_col = (col_eff == CW'(IMG_W - 1));
    last_row = (row_eff == RW'(IMG_H - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (pix_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
    emit     = pix_valid && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
    last_pix = pix_valid && last_col && last_row;
  end

  assign l1_rd = line1_mem[col_eff];
  assign l2_rd = line2_mem[col_eff];

  // Line RAMs carry no reset; windows are only emitted once both lines hold current-frame rows.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line2_mem[col_eff] <= l1_rd;
      line1_mem[col_eff] <= pix_data;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = l2_rd;
    win_d[1][2] = l1_rd;
    win_d[2][2] = pix_data;
  end

  // Element (r,k) of channel c lands at nibble 8-(3r+k): top-left in the MSBs.
  always_comb begin
    for (int c = 0; c < 8; c++) begin
      out_d[c] = '0;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          out_d[c][35 - 4*(3*r + k) -: 4] = win_d[r][k][4*c + 3 -: 4];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          win_q[r][k] <= '0;
        end
      end
      for (int c = 0; c < 8; c++) begin
        out_q[c] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= emit;
      frame_done_q <= last_pix;
      if (pix_valid) begin
        for (int r = 0; r < 3; r++) begin
          for (int k = 0; k < 3; k++) begin
            win_q[r][k] <= win_d[r][k];
          end
        end
      end
      if (emit) begin
        for (int c = 0; c < 8; c++) begin
          out_q[c] <= out_d[c];
        end
      end
    end
  end

`ifdef WIN_LAST_EN
  logic win_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_last_q <= 1'b0;
    end else begin
      win_last_q <= last_pix;
    end
  end

  assign win_last = win_last_q;
`endif

  assign win_valid    = win_valid_q;
  assign frame_done   = frame_done_q;
  assign ifm_win3x3_0 = out_q[0];
  assign ifm_win3x3_1 = out_q[1];
  assign ifm_win3x3_2 = out_q[2];
  assign ifm_win3x3_3 = out_q[3];
  assign ifm_win3x3_4 = out_q[4];
  assign ifm_win3x3_5 = out_q[5];
  assign ifm_win3x3_6 = out_q[6];
  assign ifm_win3x3_7 = out_q[7];

endmodule
